// File: rtl/fault_pkg.sv
// Shared definitions for the redundant-multiply checker stages.
// The state encoding lives here so downstream checkers can decode it too.
package fault_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FAULT = 2'd1,
        LOCK  = 2'd2
    } state_t;

    function automatic logic state_is_faulty(input state_t s);
        return s != RUN;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
// Clear wins over a same-cycle increment; the count never wraps.
module sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/fault_monitor.sv
// Compares the primary and redundant modmul products, forwards data while healthy,
// records the first mismatch and squelches the output stream once too many occur.
module fault_monitor
    import fault_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int IDX_WIDTH = 8,
    parameter int CNT_WIDTH = 8,
    parameter int THRESHOLD = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [IDX_WIDTH-1:0] in_idx,
    input  logic [WIDTH-1:0]     in_e,
    input  logic [WIDTH-1:0]     in_o,
    input  logic [WIDTH-1:0]     in_o_fault,
    input  logic                 clear,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_e,
    output logic [WIDTH-1:0]     out_o,
    output logic                 fault_flag,
    output logic                 locked,
    output logic [CNT_WIDTH-1:0] fault_count,
    output logic [IDX_WIDTH-1:0] first_idx,
    output logic [WIDTH-1:0]     first_o,
    output logic [WIDTH-1:0]     first_o_fault
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] THR     = CNT_WIDTH'(THRESHOLD);

    state_t                 state;
    state_t                 state_next;
    logic                   mismatch;
    logic                   lock_hit;
    logic                   suppress;
    logic [CNT_WIDTH-1:0]   count;
    logic [CNT_WIDTH-1:0]   count_next;

    // A mismatch that coincides with clear is ignored entirely.
    assign mismatch   = in_valid && (in_o != in_o_fault) && !clear;
    assign count_next = (count == CNT_MAX) ? count : count + CNT_ONE;
    assign lock_hit   = mismatch && (count_next >= THR);
    assign suppress   = !clear && ((state == LOCK) || lock_hit);

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = RUN;
        end else if (suppress) begin
            state_next = LOCK;
        end else if (mismatch) begin
            state_next = FAULT;
        end
    end

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (mismatch),
        .count (count)
    );

    assign fault_count = count;

    // Flags are decoded from the next state so they line up with out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            out_valid     <= 1'b0;
            out_e         <= '0;
            out_o         <= '0;
            fault_flag    <= 1'b0;
            locked        <= 1'b0;
            first_idx     <= '0;
            first_o       <= '0;
            first_o_fault <= '0;
        end else begin
            state      <= state_next;
            fault_flag <= state_is_faulty(state_next);
            locked     <= (state_next == LOCK);

            if (suppress) begin
                out_valid <= 1'b0;
                out_e     <= '0;
                out_o     <= '0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    out_e <= in_e;
                    out_o <= in_o;
                end
            end

            if (clear) begin
                first_idx     <= '0;
                first_o       <= '0;
                first_o_fault <= '0;
            end else if (mismatch && (state == RUN)) begin
                first_idx     <= in_idx;
                first_o       <= in_o;
                first_o_fault <= in_o_fault;
            end
        end
    end

endmodule

// File: tb/tb_fault_monitor.sv
// Bench for fault_monitor: a hand-derived vector table, multi-cycle corner sequences,
// then random traffic against a mismatch-counting reference model.
module tb_fault_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_idx = '0;
    logic [15:0] in_e = '0;
    logic [15:0] in_o = '0;
    logic [15:0] in_o_fault = '0;
    logic        clear = 1'b0;

    logic        out_valid, fault_flag, locked;
    logic [15:0] out_e, out_o, first_o, first_o_fault;
    logic [7:0]  fault_count, first_idx;

    logic        s_out_valid, s_fault_flag, s_locked;
    logic [15:0] s_out_e, s_out_o, s_first_o, s_first_o_fault;
    logic [1:0]  s_fault_count;
    logic [7:0]  s_first_idx;

    int tests = 0;
    int fails = 0;

    int          m_n;
    logic [7:0]  m_fidx;
    logic [15:0] m_fo, m_ffo, m_oe, m_oo;
    logic        m_ov;

    always #5 clk = ~clk;

    fault_monitor dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_idx(in_idx), .in_e(in_e),
        .in_o(in_o), .in_o_fault(in_o_fault), .clear(clear), .out_valid(out_valid),
        .out_e(out_e), .out_o(out_o), .fault_flag(fault_flag), .locked(locked),
        .fault_count(fault_count), .first_idx(first_idx), .first_o(first_o),
        .first_o_fault(first_o_fault)
    );

    fault_monitor #(.CNT_WIDTH(2), .THRESHOLD(3)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_idx(in_idx), .in_e(in_e),
        .in_o(in_o), .in_o_fault(in_o_fault), .clear(clear), .out_valid(s_out_valid),
        .out_e(s_out_e), .out_o(s_out_o), .fault_flag(s_fault_flag), .locked(s_locked),
        .fault_count(s_fault_count), .first_idx(s_first_idx), .first_o(s_first_o),
        .first_o_fault(s_first_o_fault)
    );

    typedef struct {
        logic        v;
        logic [7:0]  idx;
        logic [15:0] o;
        logic [15:0] of;
        logic        clr;
        logic        xv;
        logic [15:0] xo;
        logic        xflag;
        logic        xlock;
        logic [7:0]  xcnt;
        logic [7:0]  xfidx;
        logic [15:0] xfo;
    } vec_t;

    vec_t tbl[$];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_fidx = '0; m_fo = '0; m_ffo = '0;
        m_ov = 1'b0; m_oe = '0; m_oo = '0;
    endtask

    // Everything follows from the number of mismatches seen since reset or clear.
    task automatic model_step();
        if (clear) begin
            m_n = 0; m_fidx = '0; m_fo = '0; m_ffo = '0;
        end else if (in_valid && (in_o != in_o_fault)) begin
            if (m_n == 0) begin
                m_fidx = in_idx; m_fo = in_o; m_ffo = in_o_fault;
            end
            m_n++;
        end
        if (m_n >= 3) begin
            m_ov = 1'b0; m_oe = '0; m_oo = '0;
        end else begin
            m_ov = in_valid;
            if (in_valid) begin
                m_oe = in_e; m_oo = in_o;
            end
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [7:0] idx, input logic [15:0] e,
                                  input logic [15:0] o, input logic [15:0] of, input logic clr);
        in_valid = v; in_idx = idx; in_e = e; in_o = o; in_o_fault = of; clear = clr;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        int cap;
        cap = (m_n > 3) ? 3 : m_n;
        check_output({tag, ".out_valid"}, out_valid, m_ov);
        check_output({tag, ".out_e"}, out_e, m_oe);
        check_output({tag, ".out_o"}, out_o, m_oo);
        check_output({tag, ".fault_flag"}, fault_flag, m_n > 0);
        check_output({tag, ".locked"}, locked, m_n >= 3);
        check_output({tag, ".fault_count"}, fault_count, (m_n > 255) ? 255 : m_n);
        check_output({tag, ".first_idx"}, first_idx, m_fidx);
        check_output({tag, ".first_o"}, first_o, m_fo);
        check_output({tag, ".first_o_fault"}, first_o_fault, m_ffo);
        check_output({tag, ".small_count"}, s_fault_count, cap);
        check_output({tag, ".small_valid"}, s_out_valid, m_ov);
    endtask

    function automatic vec_t mk(input logic v, input logic [7:0] idx, input logic [15:0] o,
                                input logic [15:0] of, input logic clr, input logic xv,
                                input logic [15:0] xo, input logic xflag, input logic xlock,
                                input logic [7:0] xcnt, input logic [7:0] xfidx, input logic [15:0] xfo);
        vec_t r;
        r.v = v; r.idx = idx; r.o = o; r.of = of; r.clr = clr; r.xv = xv; r.xo = xo;
        r.xflag = xflag; r.xlock = xlock; r.xcnt = xcnt; r.xfidx = xfidx; r.xfo = xfo;
        return r;
    endfunction

    initial begin
        logic        v, c;
        logic [15:0] o, of;

        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1, 8'(k), 16'h1234 + 16'(k), 16'h1234 + 16'(k), 0,
                             1, 16'h1234 + 16'(k), 0, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 5, 16'h00A0, 16'h00A1, 0, 1, 16'h00A0, 1, 0, 1, 5, 16'h00A0));
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h00A0, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 2, 16'h0202, 16'h0203, 0, 1, 16'h0202, 1, 0, 1, 2, 16'h0202));
        tbl.push_back(mk(1, 3, 16'h0303, 16'h0303, 0, 1, 16'h0303, 1, 0, 1, 2, 16'h0202));
        tbl.push_back(mk(1, 4, 16'h0404, 16'h0405, 0, 1, 16'h0404, 1, 0, 2, 2, 16'h0202));
        tbl.push_back(mk(1, 5, 16'h0505, 16'h0505, 0, 1, 16'h0505, 1, 0, 2, 2, 16'h0202));
        tbl.push_back(mk(1, 6, 16'h0606, 16'h0607, 0, 0, 16'h0000, 1, 1, 3, 2, 16'h0202));
        tbl.push_back(mk(1, 7, 16'h0707, 16'h0707, 0, 0, 16'h0000, 1, 1, 3, 2, 16'h0202));
        tbl.push_back(mk(1, 8, 16'h0808, 16'h0809, 1, 1, 16'h0808, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 9, 16'h0909, 16'h0909, 0, 1, 16'h0909, 0, 0, 0, 0, 16'h0000));

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_output("reset.out_valid", out_valid, 0);
        check_output("reset.fault_flag", fault_flag, 0);
        check_output("reset.locked", locked, 0);
        check_output("reset.fault_count", fault_count, 0);
        check_output("reset.first_idx", first_idx, 0);
        check_output("reset.out_o", out_o, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            apply_stimulus(tbl[i].v, tbl[i].idx, 16'h00E0 + 16'(i), tbl[i].o, tbl[i].of, tbl[i].clr);
            check_output($sformatf("vec%0d.out_valid", i), out_valid, tbl[i].xv);
            check_output($sformatf("vec%0d.out_o", i), out_o, tbl[i].xo);
            check_output($sformatf("vec%0d.fault_flag", i), fault_flag, tbl[i].xflag);
            check_output($sformatf("vec%0d.locked", i), locked, tbl[i].xlock);
            check_output($sformatf("vec%0d.fault_count", i), fault_count, tbl[i].xcnt);
            check_output($sformatf("vec%0d.first_idx", i), first_idx, tbl[i].xfidx);
            check_output($sformatf("vec%0d.first_o", i), first_o, tbl[i].xfo);
        end
        check_output("vec.first_o_fault_cleared", first_o_fault, 0);

        // Saturation: the 2-bit instance must stick at 3 while the wide one keeps counting.
        apply_stimulus(0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 6; k++) begin
            apply_stimulus(1, 8'(k), 16'h1111, 16'h5000 + 16'(k), 16'h6000, 0);
            check_output($sformatf("sat%0d.small_count", k), s_fault_count, (k < 3) ? k : 3);
            check_output($sformatf("sat%0d.count", k), fault_count, k);
            check_output($sformatf("sat%0d.first_idx", k), first_idx, 1);
        end
        apply_stimulus(0, 0, 0, 0, 0, 1);
        check_model("after_sat");

        // Reset between edges while in FAULT, with a valid sample in flight.
        apply_stimulus(1, 8'h33, 16'h4444, 16'h7777, 16'h7776, 0);
        check_output("mid.fault_flag_before", fault_flag, 1);
        in_valid = 1'b1; in_o = 16'h2222; in_o_fault = 16'h2222;
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_output("mid.out_valid", out_valid, 0);
        check_output("mid.out_o", out_o, 0);
        check_output("mid.fault_flag", fault_flag, 0);
        check_output("mid.fault_count", fault_count, 0);
        check_output("mid.first_o_fault", first_o_fault, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("mid.idle_valid", out_valid, 0);
        apply_stimulus(1, 8'h40, 16'hAAAA, 16'h5151, 16'h5151, 0);
        check_output("mid.resume_valid", out_valid, 1);
        check_output("mid.resume_o", out_o, 16'h5151);

        for (int t = 0; t < 400; t++) begin
            v  = ($urandom_range(0, 3) != 0);
            o  = 16'($urandom);
            of = ($urandom_range(0, 7) == 0) ? (o ^ (16'd1 << $urandom_range(0, 15))) : o;
            c  = ($urandom_range(0, 39) == 0);
            apply_stimulus(v, 8'($urandom), 16'($urandom), o, of, c);
            check_model($sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fault_monitor.md
FAULT_MONITOR -- requirements
Module: fault_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 16: coefficient width, equal to the modmul WIDTH.
REQ-002 SHALL have parameter IDX_WIDTH, default 8: coefficient index width.
REQ-003 SHALL have parameter CNT_WIDTH, default 8: mismatch counter width.
REQ-004 SHALL have parameter THRESHOLD, default 3: mismatch count at which the block locks, range 1..2^CNT_WIDTH-1.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous reset, active-high.
REQ-007 SHALL have port in_valid, input, 1: the in_* bundle is valid this cycle.
REQ-008 SHALL have port in_idx, input, IDX_WIDTH: coefficient index aligned with the data.
REQ-009 SHALL have port in_e, input, WIDTH: pass-through even operand (modmul out_e).
REQ-010 SHALL have port in_o, input, WIDTH: primary product (modmul out_o).
REQ-011 SHALL have port in_o_fault, input, WIDTH: redundant product (modmul out_o_fault).
REQ-012 SHALL have port clear, input, 1: synchronous clear of fault state and counter.
REQ-013 SHALL have port out_valid, output, 1: the out_* bundle is valid.
REQ-014 SHALL have ports out_e and out_o, output, WIDTH each: registered pass-through data.
REQ-015 SHALL have port fault_flag, output, 1: sticky, set on any mismatch.
REQ-016 SHALL have port locked, output, 1: set when the threshold is reached.
REQ-017 SHALL have port fault_count, output, CNT_WIDTH: saturating mismatch count.
REQ-018 SHALL have port first_idx, output, IDX_WIDTH: index of the first mismatch since reset or clear.
REQ-019 SHALL have ports first_o and first_o_fault, output, WIDTH each: the value pair captured at the first mismatch.

Function
REQ-020 SHALL register every output, with exactly 1 cycle from in_valid to out_valid; there is no backpressure.
REQ-021 SHALL detect a mismatch only when in_valid=1 and in_o != in_o_fault, using a full-width compare.
REQ-022 SHALL implement FSM states RUN, FAULT, LOCK.
  - RUN->FAULT on the first mismatch.
  - FAULT->LOCK when the count reaches THRESHOLD.
  - RUN->LOCK directly when THRESHOLD=1.
REQ-023 SHALL return any state to RUN on clear=1.
  - clear has priority over a same-cycle mismatch; that mismatch is not counted or captured.
  - Data forwarding is unaffected by clear.
REQ-024 SHALL forward data in RUN and FAULT: out_valid<=in_valid; out_e/out_o<=in_e/in_o when in_valid=1, otherwise they hold.
REQ-025 SHALL, in LOCK, force out_valid to 0 and out_e/out_o to 0, and SHALL suppress the output in the same cycle as the mismatch that causes the lock.
REQ-026 SHALL update first_idx/first_o/first_o_fault only on the RUN->FAULT (or RUN->LOCK) transition; later mismatches do not overwrite them.
REQ-027 SHALL increment fault_count by 1 per mismatch and saturate at 2^CNT_WIDTH-1 with no wrap-around; it continues counting in LOCK.
REQ-028 SHALL drive fault_flag=1 in FAULT and LOCK and locked=1 only in LOCK, both as registered decodes of the state.

Reset
REQ-029 SHALL, while rst=1 asynchronously, set: state=RUN, out_valid=0, out_e=out_o=0, fault_flag=0, locked=0, fault_count=0, first_idx=0, first_o=first_o_fault=0.
REQ-030 SHALL discard any in-flight sample when reset asserts mid-stream; the first valid output after deassertion is the cycle after the first in_valid.

Structure
REQ-031 SHALL declare the state enum (RUN, FAULT, LOCK) in shared package fault_pkg, for reuse by other checker stages.
REQ-032 SHALL instantiate exactly one sub-module, sat_counter (parameter CNT_WIDTH; inputs clk, rst, clr, inc; output count), and keep the compare, capture and FSM logic in fault_monitor.

Verification
REQ-033 Clean stream: 8 valid samples with in_o=in_o_fault=0x1234+k, in_idx=k -> out_o matches 1 cycle later, fault_flag=0, fault_count=0.
REQ-034 Single fault: at idx 5, in_o=0x00A0 and in_o_fault=0x00A1 -> fault_flag=1 next cycle, first_idx=5, first_o=0x00A0, first_o_fault=0x00A1, fault_count=1, data still forwarded.
REQ-035 Lock: mismatches at idx 2, 4, 6 with THRESHOLD=3 -> locked=1 after idx 6, out_valid=0 from idx 6 onward, first_idx stays 2, fault_count=3.
REQ-036 Clear: clear=1 together with a mismatch in LOCK -> state RUN, fault_count=0, first_* =0, that mismatch not captured, forwarding resumes.
REQ-037 Saturation: CNT_WIDTH=2, THRESHOLD=3, 6 mismatches -> fault_count holds at 3.
REQ-038 Reset mid-stream: assert rst between clock edges in FAULT -> all outputs 0 immediately; after release, a clean sample gives out_valid 1 cycle later.
